// File: rtl/timer.sv
// timer: game countdown in milliseconds and rounded-up seconds, pausable, holds at zero
module timer #(
  parameter int GAME_LENGTH_SECONDS = 30,
  parameter int CLKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic [$clog2(GAME_LENGTH_SECONDS+1)-1:0] count_down_seconds,
  output logic [$clog2(1000*GAME_LENGTH_SECONDS+1)-1:0] count_down_milliseconds
);
  localparam int SW = $clog2(GAME_LENGTH_SECONDS+1);
  localparam int MW = $clog2(1000*GAME_LENGTH_SECONDS+1);
  localparam int PW = CLKS_PER_MS > 1 ? $clog2(CLKS_PER_MS) : 1;
  logic [PW-1:0] pre;
  logic [9:0] sub;
  logic run, last;
  always_comb begin
    run = enable && count_down_milliseconds != '0;
    last = pre == PW'(CLKS_PER_MS-1);
  end
  // sub counts ms elapsed in the current second, so seconds drops exactly when ms crosses a multiple of 1000
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      sub <= '0;
      count_down_milliseconds <= MW'(1000*GAME_LENGTH_SECONDS);
      count_down_seconds <= SW'(GAME_LENGTH_SECONDS);
    end else if (run) begin
      pre <= last ? '0 : pre + 1'b1;
      if (last) begin
        count_down_milliseconds <= count_down_milliseconds - 1'b1;
        sub <= sub == 10'd999 ? '0 : sub + 1'b1;
        if (sub == 10'd999) count_down_seconds <= count_down_seconds - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_timer.sv
// tb_timer: directed checks plus an elapsed-edge model compared every cycle on two timer instances
module tb_timer;
  localparam int G1 = 20, C1 = 50, T1 = G1*1000*C1;
  localparam int G2 = 2, C2 = 3, T2 = G2*1000*C2;
  logic clk = 0;
  logic rst = 1, enable;
  logic rst2 = 1, en2 = 0;
  logic [4:0] sec1;
  logic [14:0] ms1;
  logic [1:0] sec2;
  logic [10:0] ms2;
  int total = 0, bad = 0;
  int e1 = 0, e2 = 0;
  int prev2 = -1;
  bit done2 = 0;

  timer #(.GAME_LENGTH_SECONDS(G1), .CLKS_PER_MS(C1)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .count_down_seconds(sec1), .count_down_milliseconds(ms1));
  timer #(.GAME_LENGTH_SECONDS(G2), .CLKS_PER_MS(C2)) dut2 (
    .clk(clk), .rst(rst2), .enable(en2),
    .count_down_seconds(sec2), .count_down_milliseconds(ms2));

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_ms(input int e, input int g, input int c);
    return g*1000 - e/c;
  endfunction

  function automatic int exp_sec(input int e, input int g, input int c);
    return (exp_ms(e, g, c) + 999) / 1000;
  endfunction

  // model: remaining time depends only on how many enabled edges have elapsed, capped at full expiry
  always @(posedge clk or posedge rst)
    if (rst) e1 <= 0;
    else if (enable === 1'b1 && e1 < T1) e1 <= e1 + 1;

  always @(posedge clk or posedge rst2)
    if (rst2) e2 <= 0;
    else if (en2 === 1'b1 && e2 < T2) e2 <= e2 + 1;

  always @(negedge clk) begin
    chk("ms1_model", 32'(ms1), 32'(exp_ms(e1, G1, C1)));
    chk("sec1_model", 32'(sec1), 32'(exp_sec(e1, G1, C1)));
    chk("ms2_model", 32'(ms2), 32'(exp_ms(e2, G2, C2)));
    chk("sec2_model", 32'(sec2), 32'(exp_sec(e2, G2, C2)));
    if (!rst2) begin
      chk("sec2_ceil", 32'(sec2), 32'((int'(ms2) + 999) / 1000));
      if (prev2 >= 0) chk("ms2_step", 32'((prev2 - int'(ms2)) <= 1 && prev2 >= int'(ms2)), 32'd1);
      prev2 <= int'(ms2);
    end else prev2 <= -1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(3);
    rst2 = 0;
    for (int i = 0; i < 7500; i++) begin
      en2 = (i % 7) != 3;
      step(1);
    end
    en2 = 1;
    step(200);
    chk("ms2_expired", 32'(ms2), 32'd0);
    chk("sec2_expired", 32'(sec2), 32'd0);
    en2 = 0;
    step(50);
    chk("ms2_hold", 32'(ms2), 32'd0);
    chk("sec2_hold", 32'(sec2), 32'd0);
    done2 = 1;
  end

  initial begin
    enable = 1'bx;
    step(5000);
    chk("rst_ms_x", 32'(ms1), 32'd20000);
    chk("rst_sec_x", 32'(sec1), 32'd20);
    enable = 0;
    step(5000);
    chk("rst_ms", 32'(ms1), 32'd20000);
    rst = 0;
    step(4000);
    chk("idle_ms", 32'(ms1), 32'd20000);
    chk("idle_sec", 32'(sec1), 32'd20);
    enable = 1;
    step(49);
    chk("edge49_ms", 32'(ms1), 32'd20000);
    step(1);
    chk("edge50_ms", 32'(ms1), 32'd19999);
    step(150);
    chk("4ms_ms", 32'(ms1), 32'd19996);
    step(49750);
    chk("19001_ms", 32'(ms1), 32'd19001);
    chk("19001_sec", 32'(sec1), 32'd20);
    step(50);
    chk("19000_ms", 32'(ms1), 32'd19000);
    chk("19000_sec", 32'(sec1), 32'd19);
    step(20);
    enable = 0;
    step(200);
    chk("pause_ms", 32'(ms1), 32'd19000);
    enable = 1;
    step(29);
    chk("resume29_ms", 32'(ms1), 32'd19000);
    step(1);
    chk("resume30_ms", 32'(ms1), 32'd18999);
    step(10);
    #3 rst = 1;
    #1 chk("async_ms", 32'(ms1), 32'd20000);
    chk("async_sec", 32'(sec1), 32'd20);
    step(20);
    chk("rst_hold_ms", 32'(ms1), 32'd20000);
    rst = 0;
    step(50);
    chk("restart_ms", 32'(ms1), 32'd19999);
    enable = 0;
    for (int i = 0; i < 20000 && !done2; i++) step(1);
    chk("done2", 32'(done2), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
